// File: rtl/hyperbus_pkg.sv
// Shared HyperBus transfer types plus the burst splitter's state encoding and chunk sizing helper.
package hyperbus_pkg;

  typedef struct packed {
    logic        write;
    logic        address_space;
    logic        burst_type;
    logic [7:0]  burst;
    logic [31:0] address;
  } hyper_tf_t;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  strb;
    logic        last;
  } hyper_tx_t;

  typedef struct packed {
    logic [15:0] data;
    logic        error;
    logic        last;
  } hyper_rx_t;

  typedef struct packed {
    logic error;
    logic last;
  } hyper_b_t;

  typedef enum logic [2:0] {Idle, Issue, Read, Write, WaitB} splitter_state_e;

  // Words in the next chunk: whatever is left, capped at the room before the next boundary.
  function automatic logic [8:0] chunk_words(input logic [8:0] remaining, input logic [8:0] room);
    return (remaining < room) ? remaining : room;
  endfunction

endpackage

// File: rtl/hyperbus_burst_splitter.sv
// Splits linear-memory HyperBus transfers into chunks that never cross a MaxWords-aligned
// boundary, steering data beats per chunk and merging the per-chunk write responses.
module hyperbus_burst_splitter
  import hyperbus_pkg::*;
#(
  parameter int MaxWords = 16
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      in_valid_i,
  output logic      in_ready_o,
  input  hyper_tf_t in_tf_i,
  output logic      out_valid_o,
  input  logic      out_ready_i,
  output hyper_tf_t out_tf_o,
  input  logic      tx_valid_i,
  output logic      tx_ready_o,
  input  hyper_tx_t tx_i,
  output logic      phy_tx_valid_o,
  input  logic      phy_tx_ready_i,
  output hyper_tx_t phy_tx_o,
  input  logic      phy_rx_valid_i,
  output logic      phy_rx_ready_o,
  input  hyper_rx_t phy_rx_i,
  output logic      rx_valid_o,
  input  logic      rx_ready_i,
  output hyper_rx_t rx_o,
  input  logic      phy_b_valid_i,
  output logic      phy_b_ready_o,
  input  hyper_b_t  phy_b_i,
  output logic      b_valid_o,
  input  logic      b_ready_i,
  output hyper_b_t  b_o,
  output logic      busy_o
);

  localparam int OffW = $clog2(MaxWords);

  splitter_state_e state_q, state_d;
  hyper_tf_t       tf_q;
  logic [8:0]      remaining_q;
  logic [8:0]      chunk_q;
  logic [8:0]      beat_q;
  logic            err_q;

  logic       split;
  logic [8:0] room;
  logic [8:0] cur_words;
  logic       final_chunk;
  logic       beat_last;

  // tf_q.address always holds the start of the chunk about to be issued, so after the
  // first chunk it is aligned and room collapses to MaxWords.
  assign split       = ~tf_q.address_space & tf_q.burst_type;
  assign room        = 9'(MaxWords) - 9'(tf_q.address[OffW:1]);
  assign cur_words   = split ? chunk_words(remaining_q, room) : remaining_q;
  assign final_chunk = (remaining_q == 9'd0);
  assign beat_last   = (beat_q == chunk_q - 9'd1);
  assign busy_o      = (state_q != Idle);

  always_comb begin
    out_tf_o       = tf_q;
    out_tf_o.burst = 8'(cur_words - 9'd1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= Idle;
      tf_q        <= '0;
      remaining_q <= '0;
      chunk_q     <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        Idle: if (in_valid_i) begin
          tf_q        <= in_tf_i;
          remaining_q <= {1'b0, in_tf_i.burst} + 9'd1;
          err_q       <= 1'b0;
        end
        Issue: if (out_ready_i) begin
          chunk_q      <= cur_words;
          remaining_q  <= remaining_q - cur_words;
          tf_q.address <= tf_q.address + {22'd0, cur_words, 1'b0};
          beat_q       <= '0;
        end
        Write: if (tx_valid_i && phy_tx_ready_i) beat_q <= beat_q + 9'd1;
        WaitB: if (phy_b_valid_i && phy_b_ready_o) err_q <= err_q | phy_b_i.error;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d        = state_q;
    in_ready_o     = 1'b0;
    out_valid_o    = 1'b0;
    tx_ready_o     = 1'b0;
    phy_tx_valid_o = 1'b0;
    phy_tx_o       = '0;
    phy_rx_ready_o = 1'b0;
    rx_valid_o     = 1'b0;
    rx_o           = '0;
    phy_b_ready_o  = 1'b0;
    b_valid_o      = 1'b0;
    b_o            = '0;
    case (state_q)
      Idle: begin
        in_ready_o = 1'b1;
        if (in_valid_i) state_d = Issue;
      end
      Issue: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = tf_q.write ? Write : Read;
      end
      Read: begin
        rx_valid_o     = phy_rx_valid_i;
        phy_rx_ready_o = rx_ready_i;
        rx_o           = phy_rx_i;
        rx_o.last      = phy_rx_i.last & final_chunk;
        if (phy_rx_valid_i && rx_ready_i && phy_rx_i.last)
          state_d = final_chunk ? Idle : Issue;
      end
      Write: begin
        phy_tx_valid_o = tx_valid_i;
        tx_ready_o     = phy_tx_ready_i;
        phy_tx_o       = tx_i;
        phy_tx_o.last  = beat_last;
        if (tx_valid_i && phy_tx_ready_i && beat_last) state_d = WaitB;
      end
      WaitB: begin
        // Intermediate responses are absorbed here; only the final one reaches upstream.
        phy_b_ready_o = final_chunk ? b_ready_i : 1'b1;
        b_valid_o     = final_chunk & phy_b_valid_i;
        b_o.error     = err_q | phy_b_i.error;
        b_o.last      = 1'b1;
        if (phy_b_valid_i && phy_b_ready_o) state_d = final_chunk ? Idle : Issue;
      end
      default: state_d = Idle;
    endcase
  end

endmodule

// File: tb/tb_hyperbus_burst_splitter.sv
// Directed bench for hyperbus_burst_splitter with MaxWords=16.
module tb_hyperbus_burst_splitter;
  import hyperbus_pkg::*;

  logic      clk_i = 1'b0;
  logic      rst_ni;
  logic      in_valid_i;
  logic      in_ready_o;
  hyper_tf_t in_tf_i;
  logic      out_valid_o;
  logic      out_ready_i;
  hyper_tf_t out_tf_o;
  logic      tx_valid_i;
  logic      tx_ready_o;
  hyper_tx_t tx_i;
  logic      phy_tx_valid_o;
  logic      phy_tx_ready_i;
  hyper_tx_t phy_tx_o;
  logic      phy_rx_valid_i;
  logic      phy_rx_ready_o;
  hyper_rx_t phy_rx_i;
  logic      rx_valid_o;
  logic      rx_ready_i;
  hyper_rx_t rx_o;
  logic      phy_b_valid_i;
  logic      phy_b_ready_o;
  hyper_b_t  phy_b_i;
  logic      b_valid_o;
  logic      b_ready_i;
  hyper_b_t  b_o;
  logic      busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  hyperbus_burst_splitter #(.MaxWords(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_tf_i(in_tf_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_tf_o(out_tf_o),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_i(tx_i),
    .phy_tx_valid_o(phy_tx_valid_o), .phy_tx_ready_i(phy_tx_ready_i), .phy_tx_o(phy_tx_o),
    .phy_rx_valid_i(phy_rx_valid_i), .phy_rx_ready_o(phy_rx_ready_o), .phy_rx_i(phy_rx_i),
    .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .rx_o(rx_o),
    .phy_b_valid_i(phy_b_valid_i), .phy_b_ready_o(phy_b_ready_o), .phy_b_i(phy_b_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_o(b_o),
    .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_quiet(input string tag);
    chk({tag, "_busy"},      64'(busy_o),         64'd0);
    chk({tag, "_out_v"},     64'(out_valid_o),    64'd0);
    chk({tag, "_rx_v"},      64'(rx_valid_o),     64'd0);
    chk({tag, "_ptx_v"},     64'(phy_tx_valid_o), 64'd0);
    chk({tag, "_b_v"},       64'(b_valid_o),      64'd0);
    chk({tag, "_tx_rdy"},    64'(tx_ready_o),     64'd0);
    chk({tag, "_prx_rdy"},   64'(phy_rx_ready_o), 64'd0);
    chk({tag, "_pb_rdy"},    64'(phy_b_ready_o),  64'd0);
  endtask

  task automatic send_req(input string tag, input hyper_tf_t tf);
    in_valid_i = 1'b1;
    in_tf_i    = tf;
    #1;
    chk({tag, "_in_ready"}, 64'(in_ready_o), 64'd1);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    in_tf_i    = '0;
    chk({tag, "_busy"}, 64'(busy_o), 64'd1);
  endtask

  task automatic do_issue(input string tag, input logic [31:0] addr, input logic [7:0] burst,
                          input logic wr);
    int n = 0;
    out_ready_i = 1'b1;
    #1;
    while (!out_valid_o && n < 20) begin
      @(posedge clk_i); #2;
      n++;
    end
    chk({tag, "_out_valid"}, 64'(out_valid_o), 64'd1);
    chk({tag, "_addr"},      64'(out_tf_o.address), 64'(addr));
    chk({tag, "_burst"},     64'(out_tf_o.burst), 64'(burst));
    chk({tag, "_write"},     64'(out_tf_o.write), 64'(wr));
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
  endtask

  task automatic rx_beats(input string tag, input int n, input int last_at, input logic is_final);
    for (int i = 1; i <= n; i++) begin
      phy_rx_valid_i = 1'b1;
      rx_ready_i     = 1'b1;
      phy_rx_i       = '{data: 16'hA000 + 16'(i), error: (i == 2), last: (i == last_at)};
      #1;
      chk({tag, "_rx_valid"}, 64'(rx_valid_o), 64'd1);
      chk({tag, "_prx_ready"}, 64'(phy_rx_ready_o), 64'd1);
      chk({tag, "_rx_data"},  64'(rx_o.data), 64'(16'hA000 + 16'(i)));
      chk({tag, "_rx_err"},   64'(rx_o.error), 64'(i == 2));
      chk({tag, "_rx_last"},  64'(rx_o.last), 64'((i == last_at) && is_final));
      @(posedge clk_i); #1;
    end
    phy_rx_valid_i = 1'b0;
    rx_ready_i     = 1'b0;
    phy_rx_i       = '0;
  endtask

  task automatic tx_beats(input string tag, input int n);
    for (int i = 1; i <= n; i++) begin
      tx_valid_i     = 1'b1;
      phy_tx_ready_i = 1'b1;
      tx_i           = '{data: 16'h5000 + 16'(i), strb: 2'b11, last: 1'b1};
      #1;
      chk({tag, "_ptx_valid"}, 64'(phy_tx_valid_o), 64'd1);
      chk({tag, "_tx_ready"},  64'(tx_ready_o), 64'd1);
      chk({tag, "_ptx_data"},  64'(phy_tx_o.data), 64'(16'h5000 + 16'(i)));
      chk({tag, "_ptx_last"},  64'(phy_tx_o.last), 64'(i == n));
      @(posedge clk_i); #1;
    end
    tx_valid_i     = 1'b0;
    phy_tx_ready_i = 1'b0;
    tx_i           = '0;
  endtask

  task automatic b_resp(input string tag, input logic err, input logic is_final, input logic exp_err);
    phy_b_valid_i = 1'b1;
    phy_b_i       = '{error: err, last: 1'b1};
    b_ready_i     = 1'b1;
    #1;
    chk({tag, "_pb_ready"}, 64'(phy_b_ready_o), 64'd1);
    chk({tag, "_b_valid"},  64'(b_valid_o), 64'(is_final));
    if (is_final) begin
      chk({tag, "_b_err"},  64'(b_o.error), 64'(exp_err));
      chk({tag, "_b_last"}, 64'(b_o.last), 64'd1);
    end
    @(posedge clk_i); #1;
    phy_b_valid_i = 1'b0;
    phy_b_i       = '0;
    b_ready_i     = 1'b0;
    chk({tag, "_busy_after"}, 64'(busy_o), 64'(!is_final));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    hyper_tf_t tf;
    rst_ni = 1'b0;
    in_valid_i = 1'b0; in_tf_i = '0; out_ready_i = 1'b0;
    tx_valid_i = 1'b0; tx_i = '0; phy_tx_ready_i = 1'b0;
    phy_rx_valid_i = 1'b0; phy_rx_i = '0; rx_ready_i = 1'b0;
    phy_b_valid_i = 1'b0; phy_b_i = '0; b_ready_i = 1'b0;

    // Reset state
    #12;
    chk_all_quiet("rst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("rst_in_ready", 64'(in_ready_o), 64'd1);
    chk("rst_busy",     64'(busy_o),     64'd0);

    // Linear read, 4 words at 0x0: single chunk
    tf = '{write: 1'b0, address_space: 1'b0, burst_type: 1'b1, burst: 8'd3, address: 32'h0};
    send_req("r1", tf);
    do_issue("r1_c1", 32'h0, 8'd3, 1'b0);
    rx_beats("r1_c1", 4, 4, 1'b1);
    chk("r1_idle", 64'(busy_o), 64'd0);

    // Linear read at 0x1C, 6 words, with out_ready held low for 5 cycles first
    tf = '{write: 1'b0, address_space: 1'b0, burst_type: 1'b1, burst: 8'd5, address: 32'h1C};
    send_req("r2", tf);
    phy_rx_valid_i = 1'b1; rx_ready_i = 1'b1; tx_valid_i = 1'b1; phy_tx_ready_i = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("stall_out_valid", 64'(out_valid_o), 64'd1);
      chk("stall_out_tf",    64'(out_tf_o),
          64'({1'b0, 1'b0, 1'b1, 8'd1, 32'h1C}));
      chk("stall_rx_valid",  64'(rx_valid_o), 64'd0);
      chk("stall_prx_ready", 64'(phy_rx_ready_o), 64'd0);
      chk("stall_ptx_valid", 64'(phy_tx_valid_o), 64'd0);
      chk("stall_tx_ready",  64'(tx_ready_o), 64'd0);
      @(posedge clk_i); #2;
    end
    phy_rx_valid_i = 1'b0; rx_ready_i = 1'b0; tx_valid_i = 1'b0; phy_tx_ready_i = 1'b0;
    do_issue("r2_c1", 32'h1C, 8'd1, 1'b0);
    rx_beats("r2_c1", 2, 2, 1'b0);
    do_issue("r2_c2", 32'h20, 8'd3, 1'b0);
    rx_beats("r2_c2", 4, 4, 1'b1);
    chk("r2_idle", 64'(busy_o), 64'd0);

    // Linear write, 40 words: three chunks, error reported on the middle one
    tf = '{write: 1'b1, address_space: 1'b0, burst_type: 1'b1, burst: 8'd39, address: 32'h0};
    send_req("w1", tf);
    do_issue("w1_c1", 32'h0, 8'd15, 1'b1);
    tx_beats("w1_c1", 16);
    b_resp("w1_c1", 1'b0, 1'b0, 1'b0);
    do_issue("w1_c2", 32'h20, 8'd15, 1'b1);
    tx_beats("w1_c2", 16);
    b_resp("w1_c2", 1'b1, 1'b0, 1'b0);
    do_issue("w1_c3", 32'h40, 8'd7, 1'b1);
    tx_beats("w1_c3", 8);
    b_resp("w1_c3", 1'b0, 1'b1, 1'b1);

    // Register-space write crossing a boundary: never split
    tf = '{write: 1'b1, address_space: 1'b1, burst_type: 1'b1, burst: 8'd5, address: 32'h1C};
    send_req("reg", tf);
    do_issue("reg_c1", 32'h1C, 8'd5, 1'b1);
    tx_beats("reg_c1", 6);
    b_resp("reg_c1", 1'b0, 1'b1, 1'b0);

    // Wrapped read of 32 words: never split
    tf = '{write: 1'b0, address_space: 1'b0, burst_type: 1'b0, burst: 8'd31, address: 32'h10};
    send_req("wrap", tf);
    do_issue("wrap_c1", 32'h10, 8'd31, 1'b0);
    rx_beats("wrap_c1", 32, 32, 1'b1);
    chk("wrap_idle", 64'(busy_o), 64'd0);

    // Reset in the middle of chunk 2 of a split read
    tf = '{write: 1'b0, address_space: 1'b0, burst_type: 1'b1, burst: 8'd5, address: 32'h1C};
    send_req("mr", tf);
    do_issue("mr_c1", 32'h1C, 8'd1, 1'b0);
    rx_beats("mr_c1", 2, 2, 1'b0);
    do_issue("mr_c2", 32'h20, 8'd3, 1'b0);
    rx_beats("mr_c2", 1, 4, 1'b1);
    phy_rx_valid_i = 1'b1; rx_ready_i = 1'b1;
    phy_rx_i = '{data: 16'h1234, error: 1'b0, last: 1'b0};
    #1;
    chk("mr_pre_rx_valid", 64'(rx_valid_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk_all_quiet("mr_rst");
    @(posedge clk_i); #1;
    chk_all_quiet("mr_rst_hold");
    phy_rx_valid_i = 1'b0; rx_ready_i = 1'b0; phy_rx_i = '0;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    chk("mr_rel_in_ready", 64'(in_ready_o), 64'd1);
    chk("mr_rel_busy",     64'(busy_o),     64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hyperbus_burst_splitter.md
HYPERBUS_BURST_SPLITTER -- requirements
Module: hyperbus_burst_splitter

Interface
REQ-001 SHALL have parameter MaxWords, default 16, giving the maximum 16-bit words per PHY transfer; it is a power of two in the range 2..256.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-003 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have ports in_valid_i (in, 1), in_ready_o (out, 1) and in_tf_i (in, hyper_tf_t): the upstream transfer request.
REQ-005 SHALL have ports out_valid_o (out, 1), out_ready_i (in, 1) and out_tf_o (out, hyper_tf_t): the per-chunk transfer request to the PHY.
REQ-006 SHALL have ports tx_valid_i (in, 1), tx_ready_o (out, 1) and tx_i (in, hyper_tx_t): upstream write data.
REQ-007 SHALL have ports phy_tx_valid_o (out, 1), phy_tx_ready_i (in, 1) and phy_tx_o (out, hyper_tx_t): write data to the PHY.
REQ-008 SHALL have ports phy_rx_valid_i (in, 1), phy_rx_ready_o (out, 1) and phy_rx_i (in, hyper_rx_t): read data from the PHY.
REQ-009 SHALL have ports rx_valid_o (out, 1), rx_ready_i (in, 1) and rx_o (out, hyper_rx_t): read data to upstream.
REQ-010 SHALL have ports phy_b_valid_i (in, 1), phy_b_ready_o (out, 1) and phy_b_i (in, hyper_b_t): per-chunk write response from the PHY.
REQ-011 SHALL have ports b_valid_o (out, 1), b_ready_i (in, 1) and b_o (out, hyper_b_t): merged write response to upstream.
REQ-012 SHALL have port busy_o, output, 1 bit: high whenever the state is not Idle.

Function
REQ-013 SHALL use the states Idle, Issue, Read, Write and WaitB.
REQ-014 SHALL assert in_ready_o only in Idle, and move to Issue on an accepted request.
REQ-015 SHALL interpret burst as word count minus 1 and address as a byte address; the word address is address[31:1].
REQ-016 SHALL split a request only when address_space=0 and burst_type=1 (linear memory); any other request SHALL be issued unchanged as one chunk.
REQ-017 SHALL size the first chunk as min(remaining words, MaxWords - (word address mod MaxWords)), and every later chunk as min(remaining words, MaxWords).
REQ-018 SHALL drive each chunk's out_tf_o with burst = chunk words - 1 and address = previous address + 2 * previous chunk words; all other fields are copied.
REQ-019 SHALL hold out_tf_o stable while out_valid_o is high and not yet accepted.
REQ-020 SHALL, after out handshake, enter Read if write=0, otherwise Write.
REQ-021 SHALL, in Read, combinationally connect phy_rx to rx (valid/ready, data, error), with rx_o.last = phy_rx_i.last AND final chunk.
REQ-022 SHALL, on an accepted phy_rx beat with last=1, go to Issue if chunks remain, otherwise Idle.
REQ-023 SHALL, in Write, combinationally connect tx to phy_tx, with phy_tx_o.last = (beat counter = chunk words - 1), ignoring tx_i.last.
REQ-024 SHALL, in Write, go to WaitB after the last beat of the chunk is accepted.
REQ-025 SHALL, in WaitB, assert phy_b_ready_o and OR phy_b_i.error into a sticky error flag.
REQ-026 SHALL, for a non-final chunk, consume the PHY b internally and return to Issue.
REQ-027 SHALL, for the final chunk, pass the PHY b handshake through with b_o.last=1 and b_o.error = sticky flag OR phy_b_i.error, then go to Idle.
REQ-028 SHALL tie all valid/ready outputs of inactive channels to 0.
REQ-029 SHALL keep the chunk arithmetic 9 bits wide, so that burst=255 splits correctly; address carry SHALL propagate across all 32 bits.

Reset
REQ-030 SHALL, on rst_ni low, go to Idle immediately, including mid-transfer.
REQ-031 SHALL reset all counters, the sticky error flag and the held transfer register to 0.
REQ-032 SHALL drive every valid output, every ready output other than in_ready_o, and busy_o low while in reset.
REQ-033 SHALL drive in_ready_o high from the first cycle after reset release.

Structure
REQ-034 SHALL place the splitter state enum and a chunk-size function in hyperbus_pkg, alongside the existing hyper_tf_t, hyper_tx_t, hyper_rx_t and hyper_b_t.
REQ-035 SHALL be implemented as one module with no sub-modules.

Verification (MaxWords=16)
REQ-036 SHALL cover: linear read, address 0x0, burst 3 -> one chunk with address 0x0 and burst 3; 4 rx beats, last only on the 4th.
REQ-037 SHALL cover: linear read, address 0x1C, burst 5 -> chunks (0x1C, burst 1) and (0x20, burst 3); rx last only on the 6th beat, even though the PHY asserts last on beats 2 and 6.
REQ-038 SHALL cover: linear write, address 0x0, burst 39 -> chunks (0x0, 15), (0x20, 15) and (0x40, 7); phy_tx last on beats 16, 32 and 40; PHY b error=1 on chunk 2 only -> exactly one upstream b with last=1 and error=1.
REQ-039 SHALL cover: register-space write, and wrapped read with burst 31 -> each issued unchanged as a single chunk.
REQ-040 SHALL cover: rst_ni pulled low during the Read of chunk 2 -> all valid outputs 0 and busy_o 0 immediately; in_ready_o 1 in the first cycle after release.
REQ-041 SHALL cover: out_ready_i held low for 5 cycles -> out_tf_o stable throughout, and no tx or rx handshake occurs.
